pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: per-stage valid tracking, stall/flush arbitration and
// scoreboard-style pending-write counters for read-after-write interlock in ID.
module pipe_ctrl #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned NREGS  = 8,
    localparam int unsigned RW = $clog2(NREGS),
    localparam int unsigned PW = $clog2(STAGES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_valid_i,
    input  logic              imem_busy_i,
    input  logic              dmem_busy_i,
    input  logic [RW-1:0]     id_srca_i,
    input  logic [RW-1:0]     id_srcb_i,
    input  logic              id_use_a_i,
    input  logic              id_use_b_i,
    input  logic [RW-1:0]     id_dest_i,
    input  logic              id_we_i,
    input  logic              branch_taken_i,
    output logic [STAGES-1:0] stage_valid_o,
    output logic [STAGES-2:0] stage_load_o,
    output logic              load_pc_o,
    output logic              flush_o,
    output logic              hazard_stall_o,
    output logic              dmem_stall_o
);

    typedef enum logic [2:0] {
        ModeNormal,
        ModeImem,
        ModeHazard,
        ModeDmem,
        ModeFlush
    } mode_e;

    localparam logic [PW-1:0] PendMax = PW'(STAGES - 2);

    logic [STAGES-1:1] v_q, v_d;
    logic [STAGES-1:2] we_q, we_d;
    logic [RW-1:0]     dst_q [2:STAGES-1];
    logic [RW-1:0]     dst_d [2:STAGES-1];
    logic [PW-1:0]     pend_q [NREGS];
    logic [PW-1:0]     pend_d [NREGS];

    logic  if_ok, src_a_busy, src_b_busy, shift;
    logic  inc_en, dec_en, pend_err;
    mode_e mode;

    assign if_ok          = if_valid_i & ~imem_busy_i;
    assign stage_valid_o  = {v_q, if_ok};
    assign flush_o        = branch_taken_i & v_q[STAGES-1];
    assign dmem_stall_o   = dmem_busy_i & v_q[STAGES-2];
    // No write-through: a writer sitting in WB still blocks its readers this cycle.
    assign src_a_busy     = id_use_a_i & (pend_q[id_srca_i] != '0);
    assign src_b_busy     = id_use_b_i & (pend_q[id_srcb_i] != '0);
    assign hazard_stall_o = v_q[1] & (src_a_busy | src_b_busy);

    always_comb begin
        if (flush_o) begin
            mode = ModeFlush;
        end else if (dmem_stall_o) begin
            mode = ModeDmem;
        end else if (hazard_stall_o) begin
            mode = ModeHazard;
        end else if (!if_ok) begin
            mode = ModeImem;
        end else begin
            mode = ModeNormal;
        end
    end

    assign shift = (mode == ModeNormal) | (mode == ModeImem) | (mode == ModeHazard);

    always_comb begin
        v_d          = v_q;
        we_d         = we_q;
        dst_d        = dst_q;
        load_pc_o    = 1'b0;
        stage_load_o = '0;
        unique case (mode)
            ModeFlush: begin
                load_pc_o    = 1'b1;
                stage_load_o = '1;
                v_d          = '0;
                we_d         = '0;
            end
            ModeDmem: begin
                stage_load_o = '0;
            end
            ModeHazard: begin
                // ID holds its instruction; a bubble is injected into stage 2.
                stage_load_o = {{(STAGES-2){1'b1}}, 1'b0};
                v_d[2]       = 1'b0;
                we_d[2]      = 1'b0;
            end
            default: begin
                load_pc_o    = (mode == ModeNormal);
                stage_load_o = '1;
                v_d[1]       = (mode == ModeNormal);
                v_d[2]       = v_q[1];
                we_d[2]      = v_q[1] & id_we_i;
                dst_d[2]     = id_dest_i;
            end
        endcase
        if (shift) begin
            for (int i = 3; i < STAGES; i++) begin
                v_d[i]   = v_q[i-1];
                we_d[i]  = we_q[i-1];
                dst_d[i] = dst_q[i-1];
            end
        end
    end

    always_comb begin : p_pend
        logic inc, dec;
        inc      = 1'b0;
        dec      = 1'b0;
        inc_en   = v_q[1] & id_we_i & ((mode == ModeNormal) | (mode == ModeImem));
        dec_en   = v_q[STAGES-1] & we_q[STAGES-1] & (mode != ModeDmem) & (mode != ModeFlush);
        pend_err = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            inc       = inc_en & (id_dest_i == RW'(r));
            dec       = dec_en & (dst_q[STAGES-1] == RW'(r));
            pend_d[r] = pend_q[r];
            if (mode == ModeFlush) begin
                pend_d[r] = '0;
            end else if (inc && !dec) begin
                pend_err  = pend_err | (pend_q[r] == PendMax);
                pend_d[r] = pend_q[r] + PW'(1);
            end else if (dec && !inc) begin
                pend_err  = pend_err | (pend_q[r] == '0);
                pend_d[r] = pend_q[r] - PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q  <= '0;
            we_q <= '0;
            for (int i = 2; i < STAGES; i++) begin
                dst_q[i] <= '0;
            end
            for (int unsigned r = 0; r < NREGS; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            v_q    <= v_d;
            we_q   <= we_d;
            dst_q  <= dst_d;
            pend_q <= pend_d;
        end
    end

`ifndef SYNTHESIS
    pend_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !pend_err)
        else $error("pipe_ctrl: pending-write counter over/underflow");
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: drives a 5-stage/8-reg and an 8-stage/16-reg instance from shared
// stimulus and compares both against a slot-level pipeline model that scans for writers.
module tb_pipe_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_ni = 1'b0;
    logic       if_valid, imem_busy, dmem_busy, use_a, use_b, id_we, br;
    logic [3:0] srca, srcb, dest;

    logic [4:0] sv5;
    logic [3:0] sl5;
    logic       lp5, fl5, hz5, dm5;
    logic [7:0] sv8;
    logic [6:0] sl8;
    logic       lp8, fl8, hz8, dm8;

    pipe_ctrl #(.STAGES(5), .NREGS(8)) u_dut5 (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .if_valid_i     (if_valid),
        .imem_busy_i    (imem_busy),
        .dmem_busy_i    (dmem_busy),
        .id_srca_i      (srca[2:0]),
        .id_srcb_i      (srcb[2:0]),
        .id_use_a_i     (use_a),
        .id_use_b_i     (use_b),
        .id_dest_i      (dest[2:0]),
        .id_we_i        (id_we),
        .branch_taken_i (br),
        .stage_valid_o  (sv5),
        .stage_load_o   (sl5),
        .load_pc_o      (lp5),
        .flush_o        (fl5),
        .hazard_stall_o (hz5),
        .dmem_stall_o   (dm5)
    );

    pipe_ctrl #(.STAGES(8), .NREGS(16)) u_dut8 (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .if_valid_i     (if_valid),
        .imem_busy_i    (imem_busy),
        .dmem_busy_i    (dmem_busy),
        .id_srca_i      (srca),
        .id_srcb_i      (srcb),
        .id_use_a_i     (use_a),
        .id_use_b_i     (use_b),
        .id_dest_i      (dest),
        .id_we_i        (id_we),
        .branch_taken_i (br),
        .stage_valid_o  (sv8),
        .stage_load_o   (sl8),
        .load_pc_o      (lp8),
        .flush_o        (fl8),
        .hazard_stall_o (hz8),
        .dmem_stall_o   (dm8)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Model: one slot per stage 1..S-1 holding the instruction's valid/dest/write-enable.
    logic       m_v   [2][8];
    logic       m_we  [2][8];
    logic [3:0] m_dst [2][8];
    int         m_mode [2];   // 0 normal, 1 imem, 2 hazard, 3 dmem, 4 flush

    function automatic int depth(input int k);
        return (k == 0) ? 5 : 8;
    endfunction

    function automatic logic [3:0] rmask(input int k);
        return (k == 0) ? 4'h7 : 4'hF;
    endfunction

    function automatic logic pending(input int k, input logic [3:0] r);
        for (int i = 2; i < depth(k); i++) begin
            if (m_v[k][i] && m_we[k][i] && (m_dst[k][i] == r)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_v[k][i]   = 1'b0;
                m_we[k][i]  = 1'b0;
                m_dst[k][i] = 4'h0;
            end
        end
    endtask

    task automatic check_dut(input int k);
        int          s;
        logic [31:0] esv, esl, got_sv, got_sl;
        logic        sv0, efl, edm, ehz, elp, got_lp, got_fl, got_hz, got_dm;
        s   = depth(k);
        sv0 = if_valid & ~imem_busy;
        esv = 32'(sv0);
        for (int i = 1; i < s; i++) begin
            if (m_v[k][i]) esv = esv | (32'd1 << i);
        end
        efl = br & m_v[k][s-1];
        edm = dmem_busy & m_v[k][s-2];
        ehz = m_v[k][1] & ((use_a & pending(k, srca & rmask(k))) |
                           (use_b & pending(k, srcb & rmask(k))));
        if (efl)       m_mode[k] = 4;
        else if (edm)  m_mode[k] = 3;
        else if (ehz)  m_mode[k] = 2;
        else if (!sv0) m_mode[k] = 1;
        else           m_mode[k] = 0;
        esl = (32'd1 << (s - 1)) - 32'd1;
        if (m_mode[k] == 3) esl = 32'd0;
        if (m_mode[k] == 2) esl = esl & ~32'd1;
        elp = (m_mode[k] == 4) || (m_mode[k] == 0);
        if (k == 0) begin
            got_sv = 32'(sv5); got_sl = 32'(sl5);
            got_lp = lp5; got_fl = fl5; got_hz = hz5; got_dm = dm5;
        end else begin
            got_sv = 32'(sv8); got_sl = 32'(sl8);
            got_lp = lp8; got_fl = fl8; got_hz = hz8; got_dm = dm8;
        end
        check($sformatf("S%0d stage_valid", s), got_sv, esv);
        check($sformatf("S%0d stage_load", s), got_sl, esl);
        check($sformatf("S%0d load_pc", s), 32'(got_lp), 32'(elp));
        check($sformatf("S%0d flush", s), 32'(got_fl), 32'(efl));
        check($sformatf("S%0d hazard_stall", s), 32'(got_hz), 32'(ehz));
        check($sformatf("S%0d dmem_stall", s), 32'(got_dm), 32'(edm));
    endtask

    task automatic model_step(input int k);
        int s;
        s = depth(k);
        if (m_mode[k] == 4) begin
            for (int i = 1; i < s; i++) begin
                m_v[k][i]  = 1'b0;
                m_we[k][i] = 1'b0;
            end
        end else if (m_mode[k] != 3) begin
            for (int i = s - 1; i >= 3; i--) begin
                m_v[k][i]   = m_v[k][i-1];
                m_we[k][i]  = m_we[k][i-1];
                m_dst[k][i] = m_dst[k][i-1];
            end
            if (m_mode[k] == 2) begin
                m_v[k][2]  = 1'b0;
                m_we[k][2] = 1'b0;
            end else begin
                m_v[k][2]   = m_v[k][1];
                m_we[k][2]  = id_we;
                m_dst[k][2] = dest & rmask(k);
                m_v[k][1]   = if_valid & ~imem_busy;
            end
        end
    endtask

    task automatic settle_and_check();
        #4;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic advance();
        model_step(0);
        model_step(1);
        @(posedge clk_i);
        #1;
    endtask

    // Called at posedge+1; holds reset low across one edge and releases it after that edge.
    task automatic do_reset();
        rst_ni = 1'b0;
        model_clear();
        #4;
        check("rst S5 valid[4:1]", 32'(sv5[4:1]), 32'd0);
        check("rst S8 valid[7:1]", 32'(sv8[7:1]), 32'd0);
        check("rst flags", 32'({fl5, hz5, dm5, fl8, hz8, dm8}), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic rand_inputs();
        if_valid  = ($urandom_range(0, 7) != 0);
        imem_busy = ($urandom_range(0, 4) == 0);
        dmem_busy = ($urandom_range(0, 3) == 0);
        br        = ($urandom_range(0, 15) == 0);
        use_a     = 1'($urandom_range(0, 1));
        use_b     = 1'($urandom_range(0, 1));
        id_we     = 1'($urandom_range(0, 1));
        srca      = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        srcb      = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        dest      = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    endtask

    task automatic quiet_inputs();
        if_valid  = 1'b1;
        imem_busy = 1'b0;
        dmem_busy = 1'b0;
        br        = 1'b0;
        use_a     = 1'b0;
        use_b     = 1'b0;
        id_we     = 1'b0;
        srca      = 4'h0;
        srcb      = 4'h0;
        dest      = 4'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt5, cnt8, lim5, lim8;
        quiet_inputs();
        model_clear();
        @(posedge clk_i);
        #1;

        // Fill from reset: one more valid stage per edge.
        do_reset();
        for (int n = 0; n <= 8; n++) begin
            settle_and_check();
            lim5 = (n < 4) ? n : 4;
            lim8 = (n < 7) ? n : 7;
            check($sformatf("fill S5 n=%0d", n), 32'(sv5), (32'd1 << (lim5 + 1)) - 32'd1);
            check($sformatf("fill S8 n=%0d", n), 32'(sv8), (32'd1 << (lim8 + 1)) - 32'd1);
            advance();
        end

        // RAW on R3: writer in ID, then a reader of R3 directly behind it.
        for (int n = 0; n < 10; n++) begin
            settle_and_check();
            advance();
        end
        dest  = 4'd3;
        id_we = 1'b1;
        settle_and_check();
        advance();
        id_we = 1'b0;
        use_a = 1'b1;
        srca  = 4'd3;
        cnt5  = 0;
        cnt8  = 0;
        for (int n = 0; n < 12; n++) begin
            settle_and_check();
            if (hz5) cnt5++;
            if (hz8) cnt8++;
            advance();
        end
        check("S5 hazard cycles", 32'(cnt5), 32'd3);
        check("S8 hazard cycles", 32'(cnt8), 32'd6);

        // Randomized traffic with occasional asynchronous reset mid-stream.
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            settle_and_check();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
